// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types: PC sequencer states, redirect sources, and instruction size.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package riscv_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } pc_state_e;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_BR   = 2'd1,
        RD_JAL  = 2'd2,
        RD_JALR = 2'd3
    } redirect_src_e;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

    // Force an address onto a 32-bit instruction boundary
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Redirect priority encoder (JALR > JAL > branch) and target formation, with alignment check.
// Latency: purely combinational.
// Backpressure: none; sampled by pc_redirect_ctrl. Macro PC_MISALIGN_TRAP_EN selects trap-on-misalign.
module next_pc_sel
    import riscv_pkg::*;
#(
`ifdef PC_MISALIGN_TRAP_EN
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
`endif
) (
    input  logic          ex_valid_i,
    input  logic          br_taken_i,
    input  logic          jal_i,
    input  logic          jalr_i,
    input  logic [31:0]   alu_target_i,
    input  logic [31:0]   br_target_i,
    output redirect_src_e src_o,
    output logic [31:0]   target_o,
    output logic          misalign_o
);

    logic [31:0] raw_target;

    // Pick the highest-priority redirect source and its raw target
    always_comb begin
        src_o      = RD_NONE;
        raw_target = br_target_i;
        if (ex_valid_i) begin
            if (jalr_i) begin
                src_o      = RD_JALR;
                raw_target = alu_target_i & ~32'd1;
            end else if (jal_i) begin
                src_o      = RD_JAL;
            end else if (br_taken_i) begin
                src_o      = RD_BR;
            end
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    // A half-word aligned target is not fetchable: send it to the trap vector
    always_comb begin
        misalign_o = (src_o != RD_NONE) && raw_target[1];
        target_o   = misalign_o ? TRAP_VEC : word_align(raw_target);
    end
`else
    // Without trapping, misaligned targets are silently rounded down to a word
    always_comb begin
        misalign_o = 1'b0;
        target_o   = word_align(raw_target);
    end
`endif

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Program counter owner: issues fetch addresses and applies execute-stage redirects with a kill window.
// Latency: redirect cycle flushes combinationally; the new target is requested KILL_DEPTH cycles later.
// Backpressure: pc_o holds while if_ready_i is low; a redirect is the only case that withdraws if_valid_o.
// Macro PC_MISALIGN_TRAP_EN enables redirecting misaligned targets to TRAP_VEC.
module pc_redirect_ctrl
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
`ifdef PC_MISALIGN_TRAP_EN
    parameter logic [31:0] TRAP_VEC   = 32'h0000_0100,
`endif
    parameter int          KILL_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ex_valid_i,
    input  logic        br_taken_i,
    input  logic        jal_i,
    input  logic        jalr_i,
    input  logic [31:0] alu_target_i,
    input  logic [31:0] br_target_i,
    input  logic        if_ready_i,
    output logic        if_valid_o,
    output logic [31:0] pc_o,
    output logic        flush_o,
    output logic        misalign_o
);

    // Counter starts at KILL_DEPTH-1; a depth of 1 skips FLUSH entirely
    localparam logic [2:0] KILL_INIT = 3'(KILL_DEPTH - 1);

    pc_state_e     state_q;
    logic [31:0]   pc_q;
    logic [2:0]    kill_cnt_q;

    redirect_src_e sel_src;
    logic [31:0]   sel_target;
    logic          sel_misalign;
    logic          redirect;

    next_pc_sel #(
`ifdef PC_MISALIGN_TRAP_EN
        .TRAP_VEC     (TRAP_VEC)
`endif
    ) u_next_pc_sel (
        .ex_valid_i   (ex_valid_i),
        .br_taken_i   (br_taken_i),
        .jal_i        (jal_i),
        .jalr_i       (jalr_i),
        .alu_target_i (alu_target_i),
        .br_target_i  (br_target_i),
        .src_o        (sel_src),
        .target_o     (sel_target),
        .misalign_o   (sel_misalign)
    );

    // Redirects only count while fetching; in FLUSH they come from killed instructions
    always_comb begin
        redirect   = (state_q == FETCH) && (sel_src != RD_NONE);
        if_valid_o = (state_q == FETCH) && !redirect;
        flush_o    = redirect;
        misalign_o = redirect && sel_misalign;
    end

    assign pc_o = pc_q;

    // PC sequencer: boot, sequential fetch with backpressure, and redirect kill window
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            kill_cnt_q <= 3'd0;
        end else begin
            case (state_q)
                BOOT: begin
                    state_q <= FETCH;
                end
                FETCH: begin
                    if (redirect) begin
                        pc_q       <= sel_target;
                        kill_cnt_q <= KILL_INIT;
                        state_q    <= (KILL_INIT == 3'd0) ? FETCH : FLUSH;
                    end else if (if_ready_i) begin
                        pc_q <= pc_q + INSTR_BYTES;
                    end
                end
                FLUSH: begin
                    kill_cnt_q <= kill_cnt_q - 3'd1;
                    if (kill_cnt_q == 3'd1) begin
                        state_q <= FETCH;
                    end
                end
                default: begin
                    state_q <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
- Owns the program counter and sequences next-PC selection for the RISC-V core.
- Issues fetch addresses to the instruction-fetch stage over a valid/ready handshake.
- Accepts taken-branch, JAL and JALR redirects from execute, forms the JALR target, and kills wrong-path instructions with a counted flush window.
- Sits between the execute-stage target outputs and the fetch stage.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- TRAP_VEC, 32'h0000_0100, redirect address for a misaligned target (optional feature only).
- KILL_DEPTH, 2, cycles fetch stays quiet after a redirect. Legal range is 1 to 7.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- ex_valid_i  in  1  execute-stage control inputs are valid this cycle.
- br_taken_i  in  1  conditional branch resolved as taken.
- jal_i  in  1  JAL in execute.
- jalr_i  in  1  JALR in execute.
- alu_target_i  in  32  rs1+imm from the ALU (JALR target).
- br_target_i  in  32  pc+imm (branch/JAL target).
- if_ready_i  in  1  fetch stage accepts pc_o.
- if_valid_o  out  1  pc_o is a valid fetch request.
- pc_o  out  32  current fetch address.
- flush_o  out  1  one-cycle kill of IF/ID contents.
- misalign_o  out  1  one-cycle misaligned-target flag.

Behaviour:
- Reset: one clock, synchronous active-low reset (rst_ni low sampled on the clk_i edge).
  - Outputs: pc_o=RESET_PC, if_valid_o=0, flush_o=0, misalign_o=0, kill counter=0, state=BOOT.
  - Reset asserted mid-flush or mid-handshake aborts immediately to these values.
- FSM states: BOOT, FETCH, FLUSH.
  - BOOT to FETCH one cycle after reset release.
- FETCH:
  - if_valid_o=1.
  - pc_o is held stable until if_ready_i=1. On that cycle, pc_o<=pc_o+32'd4.
  - pc_o+4 wraps modulo 2^32, so 32'hFFFF_FFFC becomes 0.
- Redirect is taken when ex_valid_i=1 and any of jalr_i, jal_i or br_taken_i is set.
  - Priority: jalr_i > jal_i > br_taken_i.
  - JALR target = {alu_target_i[31:1],1'b0}.
  - JAL/branch target = br_target_i.
- On a redirect cycle:
  - pc_o<=target.
  - flush_o=1 (combinational, same cycle).
  - State goes to FLUSH; counter<=KILL_DEPTH-1.
  - A simultaneous if_ready_i is overridden: no +4 and no duplicate request.
- FLUSH:
  - if_valid_o=0.
  - Counter decrements each cycle. At 0 the state goes to FETCH with pc_o=target.
  - Redirect inputs are ignored in FLUSH, because they belong to killed wrong-path instructions.
  - A fetch request goes out exactly KILL_DEPTH cycles after the redirect cycle.
- if_valid_o may drop without if_ready_i only on a redirect, which is the only allowed handshake withdrawal.
- ex_valid_i=0 means all redirect inputs are ignored.
- Target bit 1 set (word-misaligned): handled per the optional feature.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - A redirect target with bit 1 set goes to TRAP_VEC instead of the target.
  - misalign_o=1 for that redirect cycle.
  - Flush timing is identical to a normal redirect.
- Undefined:
  - Target bits [1:0] are forced to 2'b00 silently.
  - misalign_o is tied to 0.

Decomposition:
- Shared package riscv_pkg holds:
  - pc_state_e enum {BOOT, FETCH, FLUSH}.
  - INSTR_BYTES=4 constant.
  - redirect_src_e enum {RD_NONE, RD_BR, RD_JAL, RD_JALR}.
- One sub-module, next_pc_sel: purely combinational priority encoder plus target formation (LSB clear, alignment check). It outputs the redirect source, target and misalign bit.
- The FSM, counter and PC register stay in pc_redirect_ctrl.

Test Plan:
- Reset release with RESET_PC=0 and if_ready_i=1 constant: pc_o=0 on the first FETCH cycle, then 4, 8, 12 on consecutive cycles.
- if_ready_i low for 3 cycles at pc_o=0x10: pc_o holds 0x10 and if_valid_o=1 throughout. pc_o=0x14 one cycle after if_ready_i rises.
- jal_i with br_target_i=0x200 and ex_valid_i=1, KILL_DEPTH=2:
  - flush_o=1 that cycle.
  - if_valid_o=0 for 2 cycles, then pc_o=0x200 with if_valid_o=1.
  - A br_taken_i pulse during the FLUSH window is ignored.
- jalr_i and br_taken_i together, with alu_target_i=0x301 and br_target_i=0x400: pc_o=0x300, so JALR wins and the LSB is cleared.
- alu_target_i=0x302 with jalr_i:
  - With PC_MISALIGN_TRAP_EN: pc_o=TRAP_VEC (0x100) and misalign_o pulses.
  - Without it: pc_o=0x300 and misalign_o=0.
- Wrap and reset:
  - pc_o=0xFFFF_FFFC accepted gives pc_o=0.
  - Reset asserted during FLUSH: next cycle pc_o=RESET_PC, if_valid_o=0, flush_o=0.
